controller_sequencer_bh: RTL and testbench
==========================================

Name: controller_sequencer_bh

Overview:
- SAP-1 controller-sequencer: a 6-state ring counter (T1..T6) plus an instruction decoder.
- Emits the 12-bit control word CON that drives the program counter (Cp, Ep), MAR, RAM, IR, accumulator, ALU, B and output registers.
- Sits directly upstream of the program counter: CON[11] (Cp) is the PC's COUNT input.
- Decodes the IR's upper nibble and stops the machine on HLT.

Parameters:
- OPC_LDA, 4'b0000, load accumulator opcode
- OPC_ADD, 4'b0001, add opcode
- OPC_SUB, 4'b0010, subtract opcode
- OPC_OUT, 4'b1110, output opcode
- OPC_HLT, 4'b1111, halt opcode

Ports:
- CLK_BAR  input  1  system clock, inverted; state advances on the rising edge of CLK_BAR (mid-cycle), so CON is stable when registers load
- CLR_BAR  input  1  asynchronous active-low reset
- IR_OPCODE  input  4  instruction register upper nibble
- CON  output  12  {Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar}
- T  output  6  one-hot ring state; T[0]=T1 ... T[5]=T6; 6'b000000 while halted
- HLT_BAR  output  1  active-low halt; low stops the clock generator

Behaviour:
- Reset (CLR_BAR low, asynchronous, dominant over the clock):
  - T=6'b000001 and halted flag cleared.
  - CON=12'h5E3, HLT_BAR=1.
- Ring: T1→T2→…→T6→T1, one step per rising CLK_BAR edge. Exactly one T bit is high when not halted.
- CON is combinational from T and IR_OPCODE. Idle/NOP word is 12'h3E3.
- Fetch, independent of opcode:
  - T1 = 5E3 (Ep, Lm)
  - T2 = BE3 (Cp)
  - T3 = 263 (CE, Li)
- Execute words, listed as T4/T5/T6:
  - LDA = 1A3 / 2C3 / 3E3
  - ADD = 1A3 / 2E1 / 3C7
  - SUB = 1A3 / 2E1 / 3CF
  - OUT = 3F2 / 3E3 / 3E3
  - Undefined opcodes = 3E3 / 3E3 / 3E3 (NOP)
- HLT:
  - During T4 with IR_OPCODE=OPC_HLT, CON=3E3.
  - On the next rising edge: halted set, T goes to 6'b000000, HLT_BAR goes low.
  - While halted: CON=3E3 and the state is frozen regardless of clock or opcode. Only CLR_BAR low exits halt, returning to T1.
- IR_OPCODE is sampled only in T4..T6. Its value in T1..T3 has no effect on CON.
- Reset mid-instruction: state is abandoned immediately. CON=5E3 combinationally while CLR_BAR is low.
- No illegal ring states are reachable. Any non-one-hot T while not halted recovers to T1 on the next edge.
- Cp is high in exactly one state per instruction (T2), so the PC advances exactly once per instruction.

Optional Feature:
- Macro CS_VAR_CYCLE_EN.
- Defined, variable machine cycle:
  - LDA returns T5→T1 (5 states).
  - OUT and undefined opcodes return T4→T1 (4 states).
  - ADD and SUB keep 6 states.
  - HLT is unchanged.
- Undefined: every instruction takes 6 states.
- CON values per state are identical in both builds.

Test Plan:
- Reset: assert CLR_BAR low mid-T3, release → T=000001, CON=5E3, HLT_BAR=1. First rising edge → T=000010, CON=BE3.
- LDA: IR_OPCODE=0000, run 6 edges from T1 → CON sequence 5E3, BE3, 263, 1A3, 2C3, 3E3, then 5E3 again at T1.
- ADD and SUB: opcode 0001 → T6 CON=3C7. Opcode 0010 → T6 CON=3CF. Cp is high in only one cycle per instruction.
- OUT then HLT:
  - Opcode 1110 → T4 CON=3F2.
  - Next instruction opcode 1111 → edge after T4: T=000000, HLT_BAR=0, CON=3E3.
  - 10 further edges → no change.
  - CLR_BAR pulse → T1.
- Undefined opcode 0101 → T4..T6 all 3E3 and the ring continues. With CS_VAR_CYCLE_EN: T4→T1, and LDA completes in 5 edges (T5→T1).

Source files
------------

// File: rtl/controller_sequencer_bh_if.sv
// controller_sequencer_bh_if
//   Bundles the controller-sequencer's instruction input and control outputs.
//   IR_OPCODE : instruction register upper nibble (driven by the IR side)
//   CON       : 12-bit control word {Cp,Ep,Lm_bar,CE_bar,Li_bar,Ei_bar,
//               La_bar,Ea,Su,Eu,Lb_bar,Lo_bar}
//   T         : one-hot ring state, T[0]=T1 .. T[5]=T6, all zero when halted
//   HLT_BAR   : active-low halt to the clock generator
//   Modports: master = datapath/IR side, slave = controller-sequencer.
interface controller_sequencer_bh_if;
   logic [3:0]  IR_OPCODE;
   logic [11:0] CON;
   logic [5:0]  T;
   logic        HLT_BAR;

   modport master (output IR_OPCODE, input CON, input T, input HLT_BAR);
   modport slave  (input IR_OPCODE, output CON, output T, output HLT_BAR);
endinterface

// File: rtl/controller_sequencer_bh.sv
// controller_sequencer_bh
//   SAP-1 controller-sequencer: six-state ring counter (T1..T6) plus the
//   instruction decoder producing the 12-bit control word CON.
//   Ports:
//     CLK_BAR : inverted system clock; state advances on its rising edge
//     CLR_BAR : asynchronous active-low reset (returns to T1, clears halt)
//     bus     : controller_sequencer_bh_if.slave
//               (IR_OPCODE in; CON, T, HLT_BAR out)
//   Optional build macro CS_VAR_CYCLE_EN: shortens the machine cycle
//   (LDA ends after T5; OUT and undefined opcodes end after T4).
//   CON per state is the same in both builds.
module controller_sequencer_bh #(
   parameter logic [3:0] OPC_LDA = 4'b0000,
   parameter logic [3:0] OPC_ADD = 4'b0001,
   parameter logic [3:0] OPC_SUB = 4'b0010,
   parameter logic [3:0] OPC_OUT = 4'b1110,
   parameter logic [3:0] OPC_HLT = 4'b1111
) (
   input  logic                        CLK_BAR,
   input  logic                        CLR_BAR,
   controller_sequencer_bh_if.slave    bus
);

   // State encoding is the T output itself (one-hot, zero when halted).
   typedef enum logic [5:0] {
      S_HALT = 6'b000000,
      S_T1   = 6'b000001,
      S_T2   = 6'b000010,
      S_T3   = 6'b000100,
      S_T4   = 6'b001000,
      S_T5   = 6'b010000,
      S_T6   = 6'b100000
   } state_t;

   localparam logic [11:0] CON_NOP = 12'h3E3;

   state_t      state;
   logic        hlt_bar_q;
   logic [11:0] con;

`ifdef CS_VAR_CYCLE_EN
   // Instructions whose execute phase has nothing to do after T4 / T5.
   logic end_at_t4;
   logic end_at_t5;
   assign end_at_t4 = (bus.IR_OPCODE != OPC_LDA) && (bus.IR_OPCODE != OPC_ADD) &&
                      (bus.IR_OPCODE != OPC_SUB) && (bus.IR_OPCODE != OPC_HLT);
   assign end_at_t5 = (bus.IR_OPCODE == OPC_LDA);
`endif

   always_ff @(posedge CLK_BAR or negedge CLR_BAR) begin
      if (!CLR_BAR) begin
         state     <= S_T1;
         hlt_bar_q <= 1'b1;
      end else if (hlt_bar_q) begin
         case (state)
            S_T1: state <= S_T2;
            S_T2: state <= S_T3;
            S_T3: state <= S_T4;
            S_T4: begin
               if (bus.IR_OPCODE == OPC_HLT) begin
                  state     <= S_HALT;
                  hlt_bar_q <= 1'b0;
               end
`ifdef CS_VAR_CYCLE_EN
               else if (end_at_t4) state <= S_T1;
`endif
               else state <= S_T5;
            end
            S_T5: begin
`ifdef CS_VAR_CYCLE_EN
               if (end_at_t5) state <= S_T1;
               else           state <= S_T6;
`else
               state <= S_T6;
`endif
            end
            S_T6:    state <= S_T1;
            // Any non-one-hot pattern while running (including all-zero)
            // restarts the ring.
            default: state <= S_T1;
         endcase
      end
      // Halted: state frozen until CLR_BAR.
   end

   // Control word decode; opcode only matters in T4..T6.
   always_comb begin
      con = CON_NOP;
      if (hlt_bar_q) begin
         case (state)
            S_T1: con = 12'h5E3;
            S_T2: con = 12'hBE3;
            S_T3: con = 12'h263;
            S_T4: begin
               case (bus.IR_OPCODE)
                  OPC_LDA: con = 12'h1A3;
                  OPC_ADD: con = 12'h1A3;
                  OPC_SUB: con = 12'h1A3;
                  OPC_OUT: con = 12'h3F2;
                  default: con = CON_NOP;
               endcase
            end
            S_T5: begin
               case (bus.IR_OPCODE)
                  OPC_LDA: con = 12'h2C3;
                  OPC_ADD: con = 12'h2E1;
                  OPC_SUB: con = 12'h2E1;
                  default: con = CON_NOP;
               endcase
            end
            S_T6: begin
               case (bus.IR_OPCODE)
                  OPC_ADD: con = 12'h3C7;
                  OPC_SUB: con = 12'h3CF;
                  default: con = CON_NOP;
               endcase
            end
            default: con = CON_NOP;
         endcase
      end
   end

   assign bus.CON     = con;
   assign bus.T       = state;
   assign bus.HLT_BAR = hlt_bar_q;

endmodule

// File: tb/tb_controller_sequencer_bh.sv
module tb_controller_sequencer_bh;

   logic CLK_BAR;
   logic CLR_BAR;
   int   n_pass;
   int   n_total;

   controller_sequencer_bh_if bus ();

   controller_sequencer_bh dut (
      .CLK_BAR (CLK_BAR),
      .CLR_BAR (CLR_BAR),
      .bus     (bus.slave)
   );

   initial begin
      CLK_BAR = 1'b0;
      forever #5 CLK_BAR = ~CLK_BAR;
   end

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK_BAR);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [5:0] t, input logic [11:0] con,
                            input logic hb);
      chk({tag, "_T"},   {6'b0, bus.T}, {6'b0, t});
      chk({tag, "_CON"}, bus.CON, con);
      chk({tag, "_HLT"}, {11'b0, bus.HLT_BAR}, {11'b0, hb});
   endtask

   // Runs one instruction starting from T1; opcode is held at a decoy value
   // through fetch and only presented once T3 is reached.
   task automatic do_instr(input string tag, input logic [3:0] opc, input int n,
                           input logic [11:0] w4, input logic [11:0] w5,
                           input logic [11:0] w6);
      int cp;
      cp = 0;
      bus.IR_OPCODE = ~opc;
      chk_state({tag, "_t1"}, 6'b000001, 12'h5E3, 1'b1);
      cp += int'(bus.CON[11]);
      tick();
      chk_state({tag, "_t2"}, 6'b000010, 12'hBE3, 1'b1);
      cp += int'(bus.CON[11]);
      tick();
      chk_state({tag, "_t3"}, 6'b000100, 12'h263, 1'b1);
      cp += int'(bus.CON[11]);
      bus.IR_OPCODE = opc;
      tick();
      chk_state({tag, "_t4"}, 6'b001000, w4, 1'b1);
      cp += int'(bus.CON[11]);
      if (n >= 5) begin
         tick();
         chk_state({tag, "_t5"}, 6'b010000, w5, 1'b1);
         cp += int'(bus.CON[11]);
      end
      if (n >= 6) begin
         tick();
         chk_state({tag, "_t6"}, 6'b100000, w6, 1'b1);
         cp += int'(bus.CON[11]);
      end
      tick();
      chk_state({tag, "_end"}, 6'b000001, 12'h5E3, 1'b1);
      chk({tag, "_cp_once"}, 12'(cp), 12'd1);
   endtask

   initial begin
      int lda_n;
      int short_n;
      n_pass  = 0;
      n_total = 0;
`ifdef CS_VAR_CYCLE_EN
      lda_n   = 5;
      short_n = 4;
`else
      lda_n   = 6;
      short_n = 6;
`endif
      CLR_BAR       = 1'b0;
      bus.IR_OPCODE = 4'b0000;
      #12;
      chk_state("rst_hold", 6'b000001, 12'h5E3, 1'b1);
      CLR_BAR = 1'b1;
      tick();
      chk_state("run_t2", 6'b000010, 12'hBE3, 1'b1);
      tick();
      chk_state("run_t3", 6'b000100, 12'h263, 1'b1);

      // Asynchronous reset mid-T3, no clock edge involved.
      #1 CLR_BAR = 1'b0;
      #1;
      chk_state("rst_mid", 6'b000001, 12'h5E3, 1'b1);
      #2 CLR_BAR = 1'b1;
      #1;
      chk_state("rst_rel", 6'b000001, 12'h5E3, 1'b1);
      tick();
      chk_state("rst_edge1", 6'b000010, 12'hBE3, 1'b1);

      // Back to a clean T1.
      CLR_BAR = 1'b0;
      #1 CLR_BAR = 1'b1;
      #1;

      do_instr("lda",  4'b0000, lda_n,   12'h1A3, 12'h2C3, 12'h3E3);
      do_instr("add",  4'b0001, 6,       12'h1A3, 12'h2E1, 12'h3C7);
      do_instr("sub",  4'b0010, 6,       12'h1A3, 12'h2E1, 12'h3CF);
      do_instr("und",  4'b0101, short_n, 12'h3E3, 12'h3E3, 12'h3E3);
      do_instr("out",  4'b1110, short_n, 12'h3F2, 12'h3E3, 12'h3E3);

      // HLT
      bus.IR_OPCODE = 4'b1111;
      tick();
      tick();
      chk_state("hlt_t3", 6'b000100, 12'h263, 1'b1);
      tick();
      chk_state("hlt_t4", 6'b001000, 12'h3E3, 1'b1);
      tick();
      chk_state("hlt_set", 6'b000000, 12'h3E3, 1'b0);
      for (int i = 0; i < 10; i++) begin
         bus.IR_OPCODE = 4'(i);
         tick();
         chk_state("hlt_hold", 6'b000000, 12'h3E3, 1'b0);
      end
      CLR_BAR = 1'b0;
      #1;
      chk_state("hlt_clr", 6'b000001, 12'h5E3, 1'b1);
      #1 CLR_BAR = 1'b1;
      tick();
      chk_state("hlt_exit_t2", 6'b000010, 12'hBE3, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
